// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter and instruction-fetch sequencer.
// Issues one instruction-memory request at a time, captures the returned
// word and hands it to decode together with the address it came from.
//
// Handshake semantics (all interfaces, sampled on the rising clk edge):
//   - A transfer happens in any cycle where the producer's valid-type signal
//     (o_mem_req, o_instr_valid) and the consumer's strobe (i_mem_ack,
//     i_instr_ready) are both 1. The producer holds its payload stable until
//     that cycle. i_mem_ack while o_mem_req=0 is ignored.
//   - i_load overrides every transfer in its cycle: a coincident ack is
//     dropped and a presented instruction is flushed, not consumed.
//   - After a redirect, o_mem_req stays low for one cycle so the memory
//     sees the old request end before the new address is requested.
module pc_fetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic        i_load,
    input  logic [15:0] i_load_addr,
    output logic        o_mem_req,
    output logic [15:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [15:0] i_mem_data,
    output logic [15:0] o_instr,
    output logic [15:0] o_instr_pc,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [15:0] o_pc,
    output logic [1:0]  o_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] w_pc_nxt;
    logic        r_mem_req;
    logic [15:0] r_instr;
    logic [15:0] r_instr_pc;
    logic        r_instr_valid;
    logic        w_ack;
    logic        w_capture;

    // An ack only counts while a request is actually on the bus.
    assign w_ack = i_mem_ack & r_mem_req;

    // Next-state and next-pc selection; a redirect wins over everything.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_capture   = 1'b0;
        if (i_load) begin
            w_pc_nxt    = i_load_addr;
            w_state_nxt = i_en ? S_REQ : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_en) begin
                        w_state_nxt = S_REQ;
                    end
                end
                S_REQ: begin
                    // en is deliberately ignored here: an issued request always completes.
                    if (w_ack) begin
                        w_capture   = 1'b1;
                        w_pc_nxt    = r_pc + 16'd1;
                        w_state_nxt = S_VALID;
                    end
                end
                S_VALID: begin
                    if (i_instr_ready) begin
                        w_state_nxt = i_en ? S_REQ : S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered outputs, derived from the upcoming state so they change with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_mem_req     <= 1'b0;
            r_instr       <= 16'h0000;
            r_instr_pc    <= 16'h0000;
            r_instr_valid <= 1'b0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_mem_req     <= (w_state_nxt == S_REQ) && !i_load;
            r_instr_valid <= (w_state_nxt == S_VALID);
            if (w_capture) begin
                r_instr    <= i_mem_data;
                r_instr_pc <= r_pc;
            end
        end
    end

    // The request address is always the current pc; pc only moves on
    // ack or redirect, so the address is stable for the whole request.
    assign o_mem_req     = r_mem_req;
    assign o_mem_addr    = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_instr_valid = r_instr_valid;
    assign o_pc          = r_pc;
    assign o_state       = r_state;

endmodule
